rans_freq_loader: RTL and testbench
===================================

# rans_freq_loader

Sequencer that loads a complete frequency table into the multi-stream rANS encoder and then restarts it. It reads per-symbol frequencies from a 1-cycle-latency table RAM and accumulates cumulative frequencies. It issues one frequency-write transaction per symbol on the encoder's configuration port, checks that the table sums to exactly 2^RESOLUTION, and pulses restart only for a valid table. It sits between the control-register block (start/status) and the `rans_multi_stream` configuration inputs.

## Interface
- RESOLUTION, 10, probability resolution in bits; total frequency must equal 2^RESOLUTION
- SYMBOL_WIDTH, 8, symbol width; table depth is 2^SYMBOL_WIDTH
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  begin a load; sampled only in IDLE
- busy_o  out  1  high from the cycle after an accepted start until IDLE is re-entered
- done_o  out  1  one-cycle pulse: load finished and restart issued
- err_o  out  1  sticky table error; cleared by the next accepted start
- rd_en_o  out  1  table read strobe
- rd_addr_o  out  SYMBOL_WIDTH  table read address (symbol index)
- rd_data_i  in  RESOLUTION  frequency; valid the cycle after rd_en_o
- freq_wr_o  out  1  frequency-write request to encoder
- symb_o  out  SYMBOL_WIDTH  symbol being written
- freq_o  out  RESOLUTION  symbol frequency
- cum_freq_o  out  RESOLUTION  cumulative frequency of all lower symbols
- restart_o  out  1  encoder restart request
- ready_i  in  1  encoder ready; completes freq_wr_o/restart_o transactions

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, RESTART.
- IDLE:
  - start_i=1 → clear err_o, symbol counter=0, accumulator=0 → READ.
- READ:
  - rd_en_o=1, rd_addr_o=counter → WAIT.
- WAIT:
  - Capture rd_data_i into the freq register.
  - Compute sum = acc + freq in RESOLUTION+1 bits.
  - If sum > 2^RESOLUTION: set err_o → IDLE. No write occurs for this symbol and no restart is issued.
  - Otherwise → WRITE.
- WRITE:
  - freq_wr_o=1; symb_o=counter, freq_o=freq, cum_freq_o=acc[RESOLUTION-1:0].
  - Transaction completes on the cycle freq_wr_o && ready_i.
  - On completion: acc ← sum.
  - If counter is the last symbol (all ones): → RESTART if sum == 2^RESOLUTION, else set err_o → IDLE.
  - If not the last symbol: counter+1 → READ.
- RESTART:
  - restart_o=1 until ready_i=1. Completion cycle → done_o pulses the following cycle, → IDLE.
- Zero frequencies are legal and are written (freq_o=0).
- cum_freq_o is written as the low RESOLUTION bits. It never wraps because of the overflow check; the final sum 2^RESOLUTION is never written.
- start_i outside IDLE is ignored; there is no queuing.
- The symbol counter is SYMBOL_WIDTH+1 bits internally, or equivalently the last symbol is detected as all-ones, so the 2^SYMBOL_WIDTH-symbol table never wraps to 0 mid-load.

## Timing
- Reset values:
  - All outputs are 0: busy_o, done_o, err_o, rd_en_o, rd_addr_o, freq_wr_o, symb_o, freq_o, cum_freq_o, restart_o.
  - FSM = IDLE, counter = 0, accumulator = 0.
- rst_i asserted mid-load takes effect immediately (asynchronous): all outputs drop, and the table is partially written with no restart. The next start reloads from symbol 0.
- Minimum per-symbol cost: 3 cycles (READ, WAIT, WRITE with ready_i=1).
- Minimum full load: 3·2^SYMBOL_WIDTH + 1 cycles from the first READ to restart completion; done_o follows one cycle later.
- Backpressure:
  - While freq_wr_o=1 && ready_i=0, all of freq_wr_o, symb_o, freq_o and cum_freq_o hold stable.
  - restart_o likewise holds while ready_i=0.
- freq_wr_o and restart_o are never high simultaneously. Each is registered and deasserts the cycle after completion.
- err_o rises the cycle after the failing check and holds until the next accepted start.
- done_o and err_o are mutually exclusive per load.

## Structure
- Shared package `rans_pkg`:
  - FSM state enum `loader_state_t` (IDLE, READ, WAIT, WRITE, RESTART).
  - Localparams `TOTAL_FREQ = 2**RESOLUTION` and `NUM_SYMBOLS = 2**SYMBOL_WIDTH`, as functions of the parameters.
- Single module, no sub-modules.
- The accumulator and compare are inline: one RESOLUTION+1-bit adder and comparator.

## Test plan
- Uniform table, RESOLUTION=10, SYMBOL_WIDTH=8, freq=4 for all symbols, ready_i=1 → 256 writes with cum_freq_o=4k for symbol k, one restart_o, done_o pulse, err_o=0, 769 cycles to restart completion.
- Same table, ready_i held low 5 cycles during the symbol-3 write → freq_wr_o, symb_o=3, freq_o=4, cum_freq_o=12 stable all 5 cycles; exactly one write is accepted.
- Overflow: symbol 0 freq=1000, symbol 1 freq=100 → one write (symbol 0) only; err_o=1 after the symbol-1 WAIT; no restart_o; busy_o drops.
- Undersum: all frequencies 0 → 256 writes with freq_o=0 and cum_freq_o=0; err_o=1; no restart_o; no done_o.
- rst_i pulsed while writing symbol 50 → all outputs 0 immediately; a subsequent start_i writes from symbol 0 with cum_freq_o=0.
- start_i held high throughout a load → exactly one load; no second load begins until IDLE is re-entered and start_i is re-sampled.

Source files
------------

// File: rtl/rans_pkg.sv
// Shared types and constants for the rANS frequency-table loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rans_pkg;

    localparam int DEFAULT_RESOLUTION   = 10;
    localparam int DEFAULT_SYMBOL_WIDTH = 8;

    // Table total and depth for the default configuration.
    localparam int TOTAL_FREQ  = 2 ** DEFAULT_RESOLUTION;
    localparam int NUM_SYMBOLS = 2 ** DEFAULT_SYMBOL_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESTART
    } loader_state_t;

endpackage

// File: rtl/rans_freq_loader.sv
// Loads a frequency table from RAM into the rANS encoder (one write per symbol), then restarts it.
// Latency: 3 cycles per symbol minimum (READ, WAIT, WRITE) plus 1 restart cycle; done one cycle later.
// Backpressure: freq_wr_o / restart_o and their data hold stable while ready_i is low.
module rans_freq_loader
    import rans_pkg::*;
#(
    parameter int RESOLUTION   = DEFAULT_RESOLUTION,
    parameter int SYMBOL_WIDTH = DEFAULT_SYMBOL_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    rd_en_o,
    output logic [SYMBOL_WIDTH-1:0] rd_addr_o,
    input  logic [RESOLUTION-1:0]   rd_data_i,
    output logic                    freq_wr_o,
    output logic [SYMBOL_WIDTH-1:0] symb_o,
    output logic [RESOLUTION-1:0]   freq_o,
    output logic [RESOLUTION-1:0]   cum_freq_o,
    output logic                    restart_o,
    input  logic                    ready_i
);

    // Exact table total: a single one above RESOLUTION zero bits.
    localparam logic [RESOLUTION:0] TOTAL = {1'b1, {RESOLUTION{1'b0}}};

    loader_state_t             state;
    loader_state_t             state_nxt;
    logic [SYMBOL_WIDTH-1:0]   cnt;
    logic [RESOLUTION:0]       acc;
    logic [RESOLUTION-1:0]     freq_q;
    logic                      err_q;
    logic                      done_q;

    logic [RESOLUTION:0]       sum;
    logic                      overflow;
    logic                      last_sym;
    logic                      wr_done;
    logic                      rs_done;

    // One shared adder: in WAIT the fresh RAM word is summed, in WRITE the captured one.
    assign sum      = acc + {1'b0, (state == WAIT) ? rd_data_i : freq_q};
    assign overflow = (sum > TOTAL);
    // All-ones detection means the counter never has to wrap past the last symbol.
    assign last_sym = &cnt;
    assign wr_done  = (state == WRITE) && ready_i;
    assign rs_done  = (state == RESTART) && ready_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = READ;
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = overflow ? IDLE : WRITE;
            WRITE: begin
                if (ready_i) begin
                    if (!last_sym) begin
                        state_nxt = READ;
                    end else if (sum == TOTAL) begin
                        state_nxt = RESTART;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            RESTART: if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter, accumulator, captured frequency and status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            acc    <= '0;
            freq_q <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= rs_done;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                WAIT: begin
                    freq_q <= rd_data_i;
                    if (overflow) err_q <= 1'b1;
                end
                WRITE: begin
                    if (wr_done) begin
                        acc <= sum;
                        if (!last_sym) begin
                            cnt <= cnt + SYMBOL_WIDTH'(1);
                        end else if (sum != TOTAL) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registers, so reset clears them immediately.
    assign busy_o     = (state != IDLE);
    assign rd_en_o    = (state == READ);
    assign rd_addr_o  = cnt;
    assign freq_wr_o  = (state == WRITE);
    assign symb_o     = cnt;
    assign freq_o     = freq_q;
    assign cum_freq_o = acc[RESOLUTION-1:0];
    assign restart_o  = (state == RESTART);
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_rans_freq_loader.sv
// Self-checking bench for rans_freq_loader: RAM model, negedge monitor, per-table reference model.
// Latency: n/a.
// Backpressure: ready_i is driven by the monitor (always / random / targeted stall).
module tb_rans_freq_loader;

    localparam int RES   = 10;
    localparam int SW    = 8;
    localparam int NSYM  = 256;
    localparam int TOTAL = 1024;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [RES-1:0] rd_data = '0;
    logic          busy_o, done_o, err_o, rd_en_o, freq_wr_o, restart_o;
    logic [SW-1:0] rd_addr_o, symb_o;
    logic [RES-1:0] freq_o, cum_freq_o;

    logic [RES-1:0] mem [NSYM];

    int checks = 0;
    int errors = 0;

    rans_freq_loader #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data),
        .freq_wr_o(freq_wr_o), .symb_o(symb_o), .freq_o(freq_o), .cum_freq_o(cum_freq_o),
        .restart_o(restart_o), .ready_i(ready)
    );

    always #5 clk = ~clk;

    // Table RAM with one cycle of read latency.
    always @(posedge clk) if (rd_en_o) rd_data <= mem[rd_addr_o];

    // Monitor state.
    int  cyc = 0, t_read = -1, t_restart = -1, t_done = -1;
    int  restart_cnt = 0, done_cnt = 0, err_rise = 0, stab_viol = 0, both_viol = 0, stall = 0;
    int  mode = 0;
    bit  clr_req = 0;
    bit  prev_wr_pend = 0, prev_rs_pend = 0, prev_err = 0;
    logic [SW-1:0]  p_sym;
    logic [RES-1:0] p_freq, p_cum;
    int  wr_sym[$], wr_freq[$], wr_cum[$];

    // Reference model results.
    int  exp_sym[$], exp_freq[$], exp_cum[$];
    bit  exp_err, exp_restart;

    // Observe outputs away from the active edge and decide ready for the coming edge.
    always @(negedge clk) begin
        cyc++;
        if (clr_req) begin
            wr_sym.delete(); wr_freq.delete(); wr_cum.delete();
            t_read = -1; t_restart = -1; t_done = -1;
            restart_cnt = 0; done_cnt = 0; err_rise = 0; stab_viol = 0; both_viol = 0; stall = 0;
        end
        if (rst) begin
            prev_wr_pend = 0; prev_rs_pend = 0; prev_err = 0;
        end else begin
            if (prev_wr_pend && !(freq_wr_o && symb_o == p_sym && freq_o == p_freq && cum_freq_o == p_cum))
                stab_viol++;
            if (prev_rs_pend && !restart_o) stab_viol++;
            if (freq_wr_o && restart_o) both_viol++;
            if (done_o) begin done_cnt++; t_done = cyc; end
            if (err_o && !prev_err) err_rise++;
            prev_err = err_o;
            if (rd_en_o && t_read < 0) t_read = cyc;
            case (mode)
                1: ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (freq_wr_o && symb_o == 8'd3 && stall < 5) begin ready = 1'b0; stall++; end
                    else ready = 1'b1;
                end
                default: ready = 1'b1;
            endcase
            if (freq_wr_o && ready) begin
                wr_sym.push_back(int'(symb_o)); wr_freq.push_back(int'(freq_o)); wr_cum.push_back(int'(cum_freq_o));
            end
            if (restart_o && ready) begin restart_cnt++; t_restart = cyc; end
            prev_wr_pend = freq_wr_o && !ready;
            prev_rs_pend = restart_o && !ready;
            p_sym = symb_o; p_freq = freq_o; p_cum = cum_freq_o;
        end
    end

    task automatic clear_log();
        clr_req = 1;
        @(negedge clk); #1;
        clr_req = 0;
    endtask

    // Reference: walk the table with plain integer arithmetic.
    task automatic build_model();
        int acc = 0;
        exp_sym.delete(); exp_freq.delete(); exp_cum.delete();
        exp_err = 0; exp_restart = 0;
        for (int k = 0; k < NSYM; k++) begin
            if (acc + int'(mem[k]) > TOTAL) begin exp_err = 1; break; end
            exp_sym.push_back(k); exp_freq.push_back(int'(mem[k])); exp_cum.push_back(acc % TOTAL);
            acc = acc + int'(mem[k]);
        end
        if (!exp_err) begin
            if (acc == TOTAL) exp_restart = 1;
            else exp_err = 1;
        end
    endtask

    function automatic int log_mismatches();
        int m = 0;
        int n = (wr_sym.size() < exp_sym.size()) ? wr_sym.size() : exp_sym.size();
        if (wr_sym.size() != exp_sym.size()) m++;
        for (int i = 0; i < n; i++)
            if (wr_sym[i] != exp_sym[i] || wr_freq[i] != exp_freq[i] || wr_cum[i] != exp_cum[i]) m++;
        return m;
    endfunction

    task automatic start_load(input bit hold);
        @(posedge clk); #2; start = 1;
        @(posedge clk); #2;
        if (!hold) start = 0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1;
        for (int n = 0; n < 4000; n++) begin
            if (!busy_o) begin to = 0; break; end
            @(posedge clk); #2;
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (err_o !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        checks++; if (rd_en_o !== 1'b0)   begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en_o); end
        checks++; if (rd_addr_o !== '0)   begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr_o); end
        checks++; if (freq_wr_o !== 1'b0) begin errors++; $display("FAIL reset_freq_wr: got %b expected 0", freq_wr_o); end
        checks++; if ({symb_o, freq_o, cum_freq_o} !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", {symb_o, freq_o, cum_freq_o}); end
        checks++; if (restart_o !== 1'b0) begin errors++; $display("FAIL reset_restart: got %b expected 0", restart_o); end
    endtask

    task automatic test_uniform();
        bit to;
        for (int k = 0; k < NSYM; k++) mem[k] = 10'd4;
        mode = 0; clear_log(); build_model();
        start_load(0); wait_idle(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL uniform_timeout: busy still %b expected 0", busy_o); end
        checks++; if (log_mismatches() !== 0) begin errors++; $display("FAIL uniform_writes: got %0d mismatches (%0d writes) expected 0", log_mismatches(), wr_sym.size()); end
        checks++; if (wr_cum.size() == NSYM && wr_cum[NSYM-1] !== 1020) begin errors++; $display("FAIL uniform_last_cum: got %0d expected 1020", wr_cum[NSYM-1]); end
        checks++; if (restart_cnt !== 1) begin errors++; $display("FAIL uniform_restart: got %0d expected 1", restart_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL uniform_done: got %0d expected 1", done_cnt); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL uniform_err: got %b expected 0", err_o); end
        checks++; if (t_restart - t_read + 1 !== 3 * NSYM + 1) begin errors++; $display("FAIL uniform_cycles: got %0d expected %0d", t_restart - t_read + 1, 3 * NSYM + 1); end
        checks++; if (t_done !== t_restart + 1) begin errors++; $display("FAIL uniform_done_timing: got %0d expected %0d", t_done, t_restart + 1); end
        checks++; if (both_viol !== 0) begin errors++; $display("FAIL uniform_overlap: got %0d expected 0", both_viol); end
    endtask

    task automatic test_backpressure();
        bit to;
        int n3 = 0, idx = -1;
        mode = 2; clear_log(); build_model();
        start_load(0); wait_idle(to);
        for (int i = 0; i < wr_sym.size(); i++) if (wr_sym[i] == 3) begin n3++; idx = i; end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: busy still %b expected 0", busy_o); end
        checks++; if (stall !== 5) begin errors++; $display("FAIL bp_stall: got %0d expected 5", stall); end
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_viol); end
        checks++; if (n3 !== 1) begin errors++; $display("FAIL bp_sym3_count: got %0d expected 1", n3); end
        checks++; if (idx >= 0 && (wr_cum[idx] !== 12 || wr_freq[idx] !== 4)) begin errors++; $display("FAIL bp_sym3_data: got cum %0d freq %0d expected 12 4", wr_cum[idx], wr_freq[idx]); end
        checks++; if (log_mismatches() !== 0) begin errors++; $display("FAIL bp_writes: got %0d mismatches expected 0", log_mismatches()); end
        checks++; if (restart_cnt !== 1 || done_cnt !== 1) begin errors++; $display("FAIL bp_restart_done: got %0d/%0d expected 1/1", restart_cnt, done_cnt); end
    endtask

    task automatic test_overflow();
        bit to;
        for (int k = 0; k < NSYM; k++) mem[k] = 10'($urandom_range(0, 20));
        mem[0] = 10'd1000; mem[1] = 10'd100;
        mode = 1; clear_log(); build_model();
        start_load(0); wait_idle(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL ovf_timeout: busy still %b expected 0", busy_o); end
        checks++; if (wr_sym.size() !== 1) begin errors++; $display("FAIL ovf_write_count: got %0d expected 1", wr_sym.size()); end
        checks++; if (log_mismatches() !== 0) begin errors++; $display("FAIL ovf_writes: got %0d mismatches expected 0", log_mismatches()); end
        checks++; if (err_o !== 1'b1 || err_rise !== 1) begin errors++; $display("FAIL ovf_err: got %b (rises %0d) expected 1 (1)", err_o, err_rise); end
        checks++; if (restart_cnt !== 0 || done_cnt !== 0) begin errors++; $display("FAIL ovf_restart_done: got %0d/%0d expected 0/0", restart_cnt, done_cnt); end
    endtask

    task automatic test_undersum();
        bit to;
        for (int k = 0; k < NSYM; k++) mem[k] = '0;
        mode = 0; clear_log(); build_model();
        start_load(0);
        checks++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL under_err_clear: got err %b busy %b expected 0 1", err_o, busy_o); end
        wait_idle(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL under_timeout: busy still %b expected 0", busy_o); end
        checks++; if (wr_sym.size() !== NSYM || log_mismatches() !== 0) begin errors++; $display("FAIL under_writes: got %0d writes %0d mismatches expected 256 0", wr_sym.size(), log_mismatches()); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL under_err: got %b expected 1", err_o); end
        checks++; if (restart_cnt !== 0 || done_cnt !== 0) begin errors++; $display("FAIL under_restart_done: got %0d/%0d expected 0/0", restart_cnt, done_cnt); end
    endtask

    task automatic test_random();
        bit to;
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < NSYM; k++) mem[k] = '0;
            if (it == 0) begin
                for (int u = 0; u < TOTAL; u++) begin
                    int s = $urandom_range(0, NSYM - 1);
                    mem[s] = mem[s] + 10'd1;
                end
            end else if (it == 1) begin
                for (int k = 0; k < NSYM; k++) mem[k] = 10'($urandom_range(0, 7));
            end else begin
                mem[0] = 10'd1; mem[NSYM-1] = 10'd1023;
            end
            mode = 1; clear_log(); build_model();
            start_load(0); wait_idle(to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: busy still %b expected 0", it, busy_o); end
            checks++; if (log_mismatches() !== 0) begin errors++; $display("FAIL rand%0d_writes: got %0d mismatches expected 0", it, log_mismatches()); end
            checks++; if (restart_cnt !== int'(exp_restart) || done_cnt !== int'(exp_restart)) begin errors++; $display("FAIL rand%0d_restart_done: got %0d/%0d expected %0d", it, restart_cnt, done_cnt, exp_restart); end
            checks++; if (err_o !== exp_err) begin errors++; $display("FAIL rand%0d_err: got %b expected %b", it, err_o, exp_err); end
            checks++; if (stab_viol !== 0 || both_viol !== 0) begin errors++; $display("FAIL rand%0d_handshake: got %0d/%0d expected 0/0", it, stab_viol, both_viol); end
        end
    endtask

    task automatic test_reset_mid();
        bit to, found = 0;
        for (int k = 0; k < NSYM; k++) mem[k] = 10'd4;
        mode = 0; clear_log();
        start_load(0);
        for (int n = 0; n < 1000; n++) begin
            if (freq_wr_o && symb_o == 8'd50) begin found = 1; break; end
            @(posedge clk); #2;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_reach50: got %b expected 1", found); end
        rst = 1; #1;
        checks++; if ({busy_o, done_o, err_o, rd_en_o, freq_wr_o, restart_o} !== 6'b0 || {rd_addr_o, symb_o, freq_o, cum_freq_o} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got ctl %b data %h expected 0", {busy_o, done_o, err_o, rd_en_o, freq_wr_o, restart_o}, {rd_addr_o, symb_o, freq_o, cum_freq_o}); end
        checks++; if (wr_sym.size() !== 50 || restart_cnt !== 0) begin errors++; $display("FAIL rstmid_partial: got %0d writes %0d restarts expected 50 0", wr_sym.size(), restart_cnt); end
        @(posedge clk); #2; rst = 0;
        clear_log(); build_model();
        start_load(0); wait_idle(to);
        checks++; if (wr_sym.size() == 0 || wr_sym[0] !== 0 || wr_cum[0] !== 0) begin errors++; $display("FAIL rstmid_reload_first: got %0d writes expected symbol 0 cum 0 first", wr_sym.size()); end
        checks++; if (to !== 1'b0 || log_mismatches() !== 0 || restart_cnt !== 1) begin errors++; $display("FAIL rstmid_reload: got to %b %0d mismatches %0d restarts expected 0 0 1", to, log_mismatches(), restart_cnt); end
    endtask

    task automatic test_start_held();
        bit to;
        int inorder = 1;
        for (int k = 0; k < NSYM; k++) mem[k] = 10'd4;
        mode = 0; clear_log();
        start_load(1); wait_idle(to);
        for (int i = 0; i < wr_sym.size(); i++) if (wr_sym[i] != i) inorder = 0;
        checks++; if (to !== 1'b0 || wr_sym.size() !== NSYM || inorder !== 1) begin errors++; $display("FAIL held_single_load: got %0d writes inorder %0d expected 256 1", wr_sym.size(), inorder); end
        checks++; if (restart_cnt !== 1 || done_cnt !== 1) begin errors++; $display("FAIL held_restart_done: got %0d/%0d expected 1/1", restart_cnt, done_cnt); end
        @(posedge clk); #2;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL held_resample: got busy %b expected 1", busy_o); end
        start = 0;
        wait_idle(to);
        checks++; if (to !== 1'b0 || wr_sym.size() !== 2 * NSYM || restart_cnt !== 2) begin errors++; $display("FAIL held_second_load: got %0d writes %0d restarts expected 512 2", wr_sym.size(), restart_cnt); end
    endtask

    initial begin
        for (int k = 0; k < NSYM; k++) mem[k] = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        rst = 0;
        test_uniform();
        test_backpressure();
        test_overflow();
        test_undersum();
        test_random();
        test_reset_mid();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
